mips_load_store_unit: RTL
=========================

MIPS_LOAD_STORE_UNIT -- requirements
Module: mips_load_store_unit

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid  in  1  CPU presents a memory op.
REQ-004 SHALL have port: req_ready  out  1  unit accepts an op this cycle (high only in IDLE).
REQ-005 SHALL have port: req_op  in  3  LW, LH, LHU, LB, LBU, SW, SH, SB (encoding per package).
REQ-006 SHALL have port: req_addr  in  32  byte address.
REQ-007 SHALL have port: req_wdata  in  32  store value, CPU byte order; SH/SB use the low bits.
REQ-008 SHALL have port: resp_valid  out  1  one-cycle completion pulse.
REQ-009 SHALL have port: resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-010 SHALL have port: resp_err  out  1  misaligned access, valid with resp_valid.
REQ-011 SHALL have ports: data_address out 32, data_read out 1, data_write out 1, data_writedata out 32, data_readdata in 32.
- data RAM port.
- combinational read; write on posedge.

Function
REQ-012 SHALL treat the RAM as big-endian: byte at offset k of a word occupies data_readdata[8k+7:8k]; CPU word value = byte-reversed RAM word.
REQ-013 SHALL drive data_address = {latched addr[31:2], 2'b00} and data_read/data_write high only in the states named below.
REQ-014 SHALL implement FSM IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
REQ-015 SHALL, in IDLE with req_valid, latch op/addr/wdata, then:
- misaligned (LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0) -> RESP with err;
- loads -> LOAD;
- SW -> STORE;
- SH/SB -> RMW_RD.
REQ-016 SHALL in LOAD assert data_read, register the extracted and extended result, and go to RESP.
- LB/LH sign-extend; LBU/LHU zero-extend.
REQ-017 SHALL in STORE assert data_write with data_writedata = byte-reversed wdata, and go to RESP.
REQ-018 SHALL in RMW_RD assert data_read, register the RAM word, and go to RMW_WR.
REQ-019 SHALL in RMW_WR assert data_write with the registered word, in which only the addressed byte/halfword lanes are replaced; then go to RESP.
REQ-020 SHALL in RESP pulse resp_valid for exactly one cycle and return to IDLE; resp has no backpressure.
REQ-021 SHALL meet fixed latency from the accept edge T: error T+1, loads/SW T+2, SH/SB T+3.
REQ-022 SHALL ignore req_* inputs while not in IDLE; req_valid held across RESP is accepted on the following IDLE cycle.
REQ-023 SHALL hold resp_rdata and resp_err stable until the next RESP.

Reset
REQ-024 SHALL on rst_n low, at any time including mid-RMW, immediately enter IDLE and force all outputs to 0.
- outputs: data_read, data_write, data_address, data_writedata, resp_valid, resp_rdata, resp_err.
- a partially completed RMW SHALL NOT write.
REQ-025 SHALL assert req_ready in the first cycle after rst_n deasserts.

Structure
REQ-026 SHALL place the op enum, the FSM state enum and the byte-reverse function in package mips_lsu_pkg.
REQ-027 SHALL put lane extract/extend and merge logic in a combinational sub-module mips_lsu_lane; the FSM stays in the top.

Verification
REQ-028 SHALL cover: RAM word0 = 32'h78563412; LW addr 0 -> resp_rdata 32'h12345678, resp_valid at T+2, resp_err 0.
REQ-029 SHALL cover: RAM word1 holds value 32'hEEEE68AC.
- LB addr 4 -> 32'hFFFFFFEE.
- LBU addr 4 -> 32'h000000EE.
- LH addr 6 -> 32'h000068AC.
REQ-030 SHALL cover: SB addr 1 wdata 32'h000000AB -> one read, then one write at T+2, resp at T+3.
- subsequent LW addr 0 -> 32'h12AB5678.
REQ-031 SHALL cover: SW addr 8 wdata 32'hCAFEF00D -> data_writedata 32'h0DF0FECA; subsequent LW addr 8 -> 32'hCAFEF00D.
REQ-032 SHALL cover: LW addr 2 and SH addr 5 -> resp_err 1 at T+1, resp_rdata 0, no data_read/data_write cycles.
REQ-033 SHALL cover: rst_n low during RMW_RD of SB -> RAM unchanged, all outputs 0, req_ready 1 after release.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit: op and FSM encodings,
// big-endian byte reversal and request classification.
package mips_lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

  // RAM byte k sits in bits [8k+7:8k]; the CPU sees byte 0 as the MSB.
  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic is_load(input lsu_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         return off != 2'b00;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Combinational lane logic: extracts/extends load data from a RAM word and
// builds the RAM word to write for stores (full word or merged byte/halfword).
import mips_lsu_pkg::*;

module mips_lsu_lane (
  input  lsu_op_e     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;

  assign byte_pos = {offset_i, 3'b000};
  assign half_pos = {offset_i[1], 4'b0000};

  // Big-endian halfword: lower-addressed byte is the upper half.
  always_comb begin
    byte_sel = load_word_i[byte_pos +: 8];
    half_sel = {load_word_i[half_pos +: 8], load_word_i[(half_pos + 5'd8) +: 8]};
    case (op_i)
      OP_LW:   load_data_o = byte_rev(load_word_i);
      OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data_o = {16'h0000, half_sel};
      OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data_o = {24'h000000, byte_sel};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    store_data_o = merge_word_i;
    case (op_i)
      OP_SW: store_data_o = byte_rev(wdata_i);
      OP_SH: begin
        store_data_o[half_pos +: 8]          = wdata_i[15:8];
        store_data_o[(half_pos + 5'd8) +: 8] = wdata_i[7:0];
      end
      OP_SB:   store_data_o[byte_pos +: 8] = wdata_i[7:0];
      default: store_data_o = merge_word_i;
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: accepts one op at a time, talks to a big-endian data
// RAM, uses read-modify-write for sub-word stores and reports misalignment.
import mips_lsu_pkg::*;

module mips_load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  lsu_state_e  state_q, state_d;
  lsu_op_e     op_q, op_d, req_op_e;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign req_op_e = lsu_op_e'(req_op);

  mips_lsu_lane u_lane (
    .op_i         (op_q),
    .offset_i     (addr_q[1:0]),
    .load_word_i  (data_readdata),
    .merge_word_i (word_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  // Response registers load only on entry to RESP so they hold between responses.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op_e;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (is_misaligned(req_op_e, req_addr[1:0])) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (is_load(req_op_e)) begin
            state_d = S_LOAD;
          end else if (req_op_e == OP_SW) begin
            state_d = S_STORE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_STORE, S_RMW_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        word_d  = data_readdata;
        state_d = S_RMW_WR;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = (state_q == S_RESP);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign data_address   = {addr_q[31:2], 2'b00};
  assign data_read      = (state_q == S_LOAD) || (state_q == S_RMW_RD);
  assign data_write     = (state_q == S_STORE) || (state_q == S_RMW_WR);
  assign data_writedata = data_write ? store_data : '0;

endmodule
